// File: rtl/av_io_arbiter.sv
// av_io_arbiter
//   Three-way round-robin arbiter (CPU, copper, DMA) in front of a single
//   Wishbone-style I/O bridge port, with bus timeout and optional cycle lock.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-low reset
//   s_cyc_i/s_stb_i/s_we_i  per-requester cycle, strobe, write enable (bit n = requester n)
//   s_sel_i, s_adr_i, s_dat_i  packed per-requester byte selects, address, write data
//   s_ack_o, s_err_o        per-requester acknowledge / timeout error
//   s_dat_o                 shared read data, qualified by s_ack_o
//   m_*                     master port toward the I/O bridge
//   gnt_o                   one-hot current grant, 000 when idle
module av_io_arbiter #(
  parameter int unsigned TO_CYCLES = 255,
  parameter bit          LOCK_EN   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  s_cyc_i,
  input  logic [2:0]  s_stb_i,
  input  logic [2:0]  s_we_i,
  input  logic [11:0] s_sel_i,
  input  logic [95:0] s_adr_i,
  input  logic [95:0] s_dat_i,
  output logic [2:0]  s_ack_o,
  output logic [2:0]  s_err_o,
  output logic [31:0] s_dat_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic        m_ack_i,
  input  logic        m_stall_i,
  input  logic [31:0] m_dat_i,
  output logic [2:0]  gnt_o
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_NACK, ERR} state_e;

  localparam logic [9:0] TO_LAST = 10'(TO_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  gidx_q, gidx_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [2:0]  ack_q, ack_d;
  logic [2:0]  err_q, err_d;
  logic [31:0] sdat_q, sdat_d;
  logic        mcyc_q, mcyc_d;
  logic        mstb_q, mstb_d;
  logic        mwe_q, mwe_d;
  logic [3:0]  msel_q, msel_d;
  logic [31:0] madr_q, madr_d;
  logic [31:0] mdat_q, mdat_d;

  logic [2:0]  req;
  logic        win_vld;
  logic [1:0]  win_idx;
  logic [1:0]  cand;
  logic        g_cyc, g_stb, g_we;
  logic [3:0]  g_sel;
  logic [31:0] g_adr, g_dat;
  logic [2:0]  g_hot;
  logic        clr_m;

  assign req   = s_cyc_i & s_stb_i;
  assign g_cyc = s_cyc_i[gidx_q];
  assign g_stb = s_stb_i[gidx_q];
  assign g_we  = s_we_i[gidx_q];
  assign g_sel = s_sel_i[{gidx_q, 2'b00} +: 4];
  assign g_adr = s_adr_i[{gidx_q, 5'b00000} +: 32];
  assign g_dat = s_dat_i[{gidx_q, 5'b00000} +: 32];
  assign g_hot = 3'b001 << gidx_q;

  // Search starts one past the last winner, so the last winner ranks lowest.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    cand    = '0;
    for (int unsigned k = 1; k <= 3; k++) begin
      cand = 2'((32'(ptr_q) + k) % 3);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    ack_d   = ack_q;
    err_d   = err_q;
    sdat_d  = sdat_q;
    mcyc_d  = mcyc_q;
    mstb_d  = mstb_q;
    mwe_d   = mwe_q;
    msel_d  = msel_q;
    madr_d  = madr_q;
    mdat_d  = mdat_q;
    clr_m   = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_vld && !m_stall_i && !m_ack_i) begin
          gidx_d  = win_idx;
          ptr_d   = win_idx;
          gnt_d   = 3'b001 << win_idx;
          state_d = ISSUE;
        end
      end
      // Also the re-entry point for a locked requester: waits for its next strobe.
      ISSUE: begin
        if (!g_cyc) begin
          gnt_d   = '0;
          state_d = IDLE;
        end else if (g_stb) begin
          mcyc_d  = 1'b1;
          mstb_d  = 1'b1;
          mwe_d   = g_we;
          msel_d  = g_sel;
          madr_d  = g_adr;
          mdat_d  = g_dat;
          cnt_d   = '0;
          state_d = WAIT_ACK;
        end
      end
      // Abort outranks a same-cycle ack so a vanished requester never sees one.
      WAIT_ACK: begin
        if (!g_cyc) begin
          clr_m   = 1'b1;
          gnt_d   = '0;
          state_d = IDLE;
        end else if (m_ack_i) begin
          clr_m   = 1'b1;
          sdat_d  = mwe_q ? '0 : m_dat_i;
          ack_d   = g_hot;
          state_d = WAIT_NACK;
        end else if (cnt_q == TO_LAST) begin
          clr_m   = 1'b1;
          err_d   = g_hot;
          state_d = ERR;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 10'd1;
        end
      end
      WAIT_NACK: begin
        if (!g_stb) begin
          ack_d  = '0;
          sdat_d = '0;
          if (LOCK_EN && g_cyc) begin
            state_d = ISSUE;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      ERR: begin
        if (!g_stb) begin
          err_d   = '0;
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr_m) begin
      mcyc_d = 1'b0;
      mstb_d = 1'b0;
      mwe_d  = 1'b0;
      msel_d = '0;
      madr_d = '0;
      mdat_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      ptr_q   <= 2'd2;
      gidx_q  <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      sdat_q  <= '0;
      mcyc_q  <= 1'b0;
      mstb_q  <= 1'b0;
      mwe_q   <= 1'b0;
      msel_q  <= '0;
      madr_q  <= '0;
      mdat_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      sdat_q  <= sdat_d;
      mcyc_q  <= mcyc_d;
      mstb_q  <= mstb_d;
      mwe_q   <= mwe_d;
      msel_q  <= msel_d;
      madr_q  <= madr_d;
      mdat_q  <= mdat_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign s_ack_o = ack_q;
  assign s_err_o = err_q;
  assign s_dat_o = sdat_q;
  assign m_cyc_o = mcyc_q;
  assign m_stb_o = mstb_q;
  assign m_we_o  = mwe_q;
  assign m_sel_o = msel_q;
  assign m_adr_o = madr_q;
  assign m_dat_o = mdat_q;

endmodule

// File: tb/tb_av_io_arbiter.sv
// tb_av_io_arbiter
//   Drives two arbiters (LOCK_EN=0 and LOCK_EN=1) from the same inputs and
//   compares every output on every falling edge against a transaction-phase
//   reference model, plus directed scenario checks.
module tb_av_io_arbiter;

  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  cyc = '0, stb = '0, we = '0;
  logic [11:0] sel = '0;
  logic [95:0] adr = '0, dat = '0;
  logic        m_ack = 1'b0, m_stall = 1'b0;
  logic [31:0] m_dat = '0;

  logic [2:0]  d_gnt [2];
  logic [2:0]  d_ack [2];
  logic [2:0]  d_err [2];
  logic [31:0] d_sdat [2];
  logic        d_mcyc [2];
  logic        d_mstb [2];
  logic        d_mwe [2];
  logic [3:0]  d_msel [2];
  logic [31:0] d_madr [2];
  logic [31:0] d_mdat [2];

  logic [111:0] act_v [2];
  logic [111:0] exp_v [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  av_io_arbiter #(.TO_CYCLES(TO), .LOCK_EN(1'b0)) u0 (
    .clk_i(clk), .rst_i(rst_n), .s_cyc_i(cyc), .s_stb_i(stb), .s_we_i(we),
    .s_sel_i(sel), .s_adr_i(adr), .s_dat_i(dat), .s_ack_o(d_ack[0]), .s_err_o(d_err[0]),
    .s_dat_o(d_sdat[0]), .m_cyc_o(d_mcyc[0]), .m_stb_o(d_mstb[0]), .m_we_o(d_mwe[0]),
    .m_sel_o(d_msel[0]), .m_adr_o(d_madr[0]), .m_dat_o(d_mdat[0]), .m_ack_i(m_ack),
    .m_stall_i(m_stall), .m_dat_i(m_dat), .gnt_o(d_gnt[0]));

  av_io_arbiter #(.TO_CYCLES(TO), .LOCK_EN(1'b1)) u1 (
    .clk_i(clk), .rst_i(rst_n), .s_cyc_i(cyc), .s_stb_i(stb), .s_we_i(we),
    .s_sel_i(sel), .s_adr_i(adr), .s_dat_i(dat), .s_ack_o(d_ack[1]), .s_err_o(d_err[1]),
    .s_dat_o(d_sdat[1]), .m_cyc_o(d_mcyc[1]), .m_stb_o(d_mstb[1]), .m_we_o(d_mwe[1]),
    .m_sel_o(d_msel[1]), .m_adr_o(d_madr[1]), .m_dat_o(d_mdat[1]), .m_ack_i(m_ack),
    .m_stall_i(m_stall), .m_dat_i(m_dat), .gnt_o(d_gnt[1]));

  // Next owner: first active requester strictly after the last winner, wrapping.
  function automatic int rr_pick(input logic [2:0] r, input int last);
    for (int k = 1; k <= 3; k++)
      if (r[(last + k) % 3]) return (last + k) % 3;
    return last;
  endfunction

  typedef enum int {PH_FREE, PH_GRANTED, PH_ON_BUS, PH_ACKED, PH_ERRED} phase_t;

  for (genvar gi = 0; gi < 2; gi++) begin : g_mdl
    localparam bit LK = (gi == 1);
    phase_t      ph;
    int          own, last, elapsed;
    logic [2:0]  e_gnt, e_ack, e_err;
    logic        e_cyc, e_stb, e_we;
    logic [3:0]  e_sel;
    logic [31:0] e_sdat, e_adr, e_mdat;
    logic        done;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ph <= PH_FREE; own <= 0; last <= 2; elapsed <= 0;
        e_gnt <= '0; e_ack <= '0; e_err <= '0; e_sdat <= '0;
        {e_cyc, e_stb, e_we, e_sel, e_adr, e_mdat} <= '0;
      end else begin
        case (ph)
          PH_FREE:
            if ((cyc & stb) != 3'b000 && !m_stall && !m_ack) begin
              own   <= rr_pick(cyc & stb, last);
              last  <= rr_pick(cyc & stb, last);
              e_gnt <= 3'(1 << rr_pick(cyc & stb, last));
              ph    <= PH_GRANTED;
            end
          PH_GRANTED:
            if (!cyc[own]) begin
              e_gnt <= '0; ph <= PH_FREE;
            end else if (stb[own]) begin
              e_cyc <= 1'b1; e_stb <= 1'b1; e_we <= we[own];
              e_sel <= sel[4*own +: 4]; e_adr <= adr[32*own +: 32]; e_mdat <= dat[32*own +: 32];
              elapsed <= 0; ph <= PH_ON_BUS;
            end
          PH_ON_BUS: begin
            if (!cyc[own] || m_ack || elapsed + 1 == TO)
              {e_cyc, e_stb, e_we, e_sel, e_adr, e_mdat} <= '0;
            if (!cyc[own]) begin
              e_gnt <= '0; ph <= PH_FREE;
            end else if (m_ack) begin
              e_sdat <= e_we ? 32'h0 : m_dat; e_ack <= 3'(1 << own); ph <= PH_ACKED;
            end else begin
              elapsed <= elapsed + 1;
              if (elapsed + 1 == TO) begin
                e_err <= 3'(1 << own); ph <= PH_ERRED;
              end
            end
          end
          PH_ACKED:
            if (!stb[own]) begin
              e_ack <= '0; e_sdat <= '0;
              if (LK && cyc[own]) ph <= PH_GRANTED;
              else begin e_gnt <= '0; ph <= PH_FREE; end
            end
          PH_ERRED:
            if (!stb[own]) begin
              e_err <= '0; e_gnt <= '0; ph <= PH_FREE;
            end
          default: ph <= PH_FREE;
        endcase
      end
    end

    assign exp_v[gi] = {e_gnt, e_ack, e_err, e_cyc, e_stb, e_we, e_sel, e_sdat, e_adr, e_mdat};
    assign act_v[gi] = {d_gnt[gi], d_ack[gi], d_err[gi], d_mcyc[gi], d_mstb[gi], d_mwe[gi],
                        d_msel[gi], d_sdat[gi], d_madr[gi], d_mdat[gi]};
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare both arbiters to the model.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("ctl%0d", i), {16'h0, act_v[i][111:96]}, {16'h0, exp_v[i][111:96]});
      check_eq($sformatf("sdat%0d", i), act_v[i][95:64], exp_v[i][95:64]);
      check_eq($sformatf("madr%0d", i), act_v[i][63:32], exp_v[i][63:32]);
      check_eq($sformatf("mdat%0d", i), act_v[i][31:0], exp_v[i][31:0]);
    end
  endtask

  task automatic idle_inputs();
    cyc = '0; stb = '0; we = '0; sel = '0; adr = '0; dat = '0;
    m_ack = 1'b0; m_stall = 1'b0; m_dat = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic set_req(input int n, input logic c, input logic w, input logic [31:0] a,
                         input logic [31:0] d);
    cyc[n] = c; stb[n] = c; we[n] = w;
    sel[4*n +: 4] = 4'hF; adr[32*n +: 32] = a; dat[32*n +: 32] = d;
  endtask

  task automatic wait_mcyc(input int u);
    int w = 0;
    while (!d_mcyc[u] && w < 10) begin tick(); w++; end
    check_eq("mcyc_wait", 32'(d_mcyc[u]), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gseq[$];
    int acc[$];
    int cnt, cpu_ph;
    int exp036[4];
    logic [2:0] prev;

    // Reset state
    do_reset();
    for (int i = 0; i < 2; i++) begin
      check_eq("rst_ctl", {16'h0, act_v[i][111:96]}, 32'h0);
      check_eq("rst_sdat", d_sdat[i], 32'h0);
    end

    // CPU read with a slave that acks three cycles after the strobe
    set_req(0, 1'b1, 1'b0, 32'hFD00_0010, 32'h0);
    tick();
    check_eq("rd_gnt", 32'(d_gnt[0]), 32'b001);
    check_eq("rd_mcyc_early", 32'(d_mcyc[0]), 32'd0);
    tick();
    check_eq("rd_mcyc", 32'(d_mcyc[0]), 32'd1);
    check_eq("rd_madr", d_madr[0], 32'hFD00_0010);
    tick(); tick();
    m_ack = 1'b1; m_dat = 32'hCAFE_BABE;
    tick();
    m_ack = 1'b0; m_dat = '0;
    check_eq("rd_ack", 32'(d_ack[0]), 32'b001);
    check_eq("rd_sdat", d_sdat[0], 32'hCAFE_BABE);
    check_eq("rd_mcyc_drop", 32'(d_mcyc[0]), 32'd0);
    tick();
    check_eq("rd_ack_hold", 32'(d_ack[0]), 32'b001);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    tick();
    check_eq("rd_ack_clr", 32'(d_ack[0]), 32'b000);
    check_eq("rd_sdat_clr", d_sdat[0], 32'h0);
    check_eq("rd_gnt_clr", 32'(d_gnt[0]), 32'b000);

    // Three simultaneous requesters, one-cycle ack slave, no lock
    do_reset();
    cyc = 3'b111; stb = 3'b111;
    prev = '0;
    for (int c = 0; c < 60 && gseq.size() < 4; c++) begin
      tick();
      if (prev == 3'b000 && d_gnt[0] != 3'b000) gseq.push_back(int'(d_gnt[0]));
      prev = d_gnt[0];
      m_ack = d_mstb[0];
      for (int n = 0; n < 3; n++) begin
        cyc[n] = !d_ack[0][n];
        stb[n] = !d_ack[0][n];
      end
    end
    exp036 = '{1, 2, 4, 1};
    check_eq("rr_count", 32'(gseq.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      check_eq($sformatf("rr_gnt%0d", k), (k < gseq.size()) ? 32'(gseq[k]) : 32'h0, 32'(exp036[k]));

    // Slave never acks: timeout
    do_reset();
    set_req(0, 1'b1, 1'b1, 32'hFD00_0020, 32'h1234_5678);
    wait_mcyc(0);
    cnt = 0;
    while (!d_err[0][0] && cnt < 400) begin tick(); cnt++; end
    check_eq("to_cycles", 32'(cnt), 32'(TO));
    check_eq("to_err", 32'(d_err[0]), 32'b001);
    check_eq("to_mcyc", 32'(d_mcyc[0]), 32'd0);
    check_eq("to_ack", 32'(d_ack[0]), 32'b000);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    tick();
    check_eq("to_err_clr", 32'(d_err[0]), 32'b000);
    check_eq("to_gnt_clr", 32'(d_gnt[0]), 32'b000);

    // Copper aborts mid-access; late ack ignored; DMA granted next
    do_reset();
    set_req(1, 1'b1, 1'b0, 32'hFD00_0100, 32'h0);
    set_req(2, 1'b1, 1'b0, 32'hFD00_0200, 32'h0);
    wait_mcyc(0);
    check_eq("ab_gnt", 32'(d_gnt[0]), 32'b010);
    tick(); tick();
    cyc[1] = 1'b0; stb[1] = 1'b0;
    tick();
    check_eq("ab_mcyc", 32'(d_mcyc[0]), 32'd0);
    check_eq("ab_gnt_idle", 32'(d_gnt[0]), 32'b000);
    m_ack = 1'b1; m_dat = 32'hDEAD_BEEF;
    tick();
    check_eq("ab_no_ack", 32'(d_ack[0]), 32'b000);
    m_ack = 1'b0; m_dat = '0;
    tick();
    check_eq("ab_dma_gnt", 32'(d_gnt[0]), 32'b100);
    idle_inputs();
    tick(); tick();

    // Locked read-modify-write by CPU while DMA waits
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'hFD00_0040, 32'h0);
    set_req(2, 1'b1, 1'b0, 32'hFD00_0300, 32'h0);
    cpu_ph = 0;
    for (int c = 0; c < 80 && acc.size() < 3; c++) begin
      tick();
      if (d_mstb[1]) acc.push_back(int'(d_gnt[1]));
      m_ack = d_mstb[1];
      case (cpu_ph)
        0: if (d_ack[1][0]) begin stb[0] = 1'b0; cpu_ph = 1; end
        1: begin stb[0] = 1'b1; we[0] = 1'b1; dat[31:0] = 32'h0000_00A5; cpu_ph = 2; end
        2: if (d_ack[1][0]) begin cyc[0] = 1'b0; stb[0] = 1'b0; cpu_ph = 3; end
        default: ;
      endcase
      if (d_ack[1][2]) begin cyc[2] = 1'b0; stb[2] = 1'b0; end
    end
    check_eq("rmw_count", 32'(acc.size()), 32'd3);
    check_eq("rmw_acc0", (acc.size() > 0) ? 32'(acc[0]) : 32'h0, 32'b001);
    check_eq("rmw_acc1", (acc.size() > 1) ? 32'(acc[1]) : 32'h0, 32'b001);
    check_eq("rmw_acc2", (acc.size() > 2) ? 32'(acc[2]) : 32'h0, 32'b100);
    idle_inputs();
    tick(); tick(); tick();

    // Asynchronous reset in the middle of an access
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'hFD00_0050, 32'h0);
    wait_mcyc(0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq("ar_ctl", {16'h0, act_v[i][111:96]}, 32'h0);
      check_eq("ar_madr", d_madr[i], 32'h0);
    end
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check_eq("ar_gnt_idle", 32'(d_gnt[0]), 32'b000);
    check_eq("ar_mcyc_idle", 32'(d_mcyc[0]), 32'd0);
    set_req(0, 1'b1, 1'b0, 32'hFD00_0060, 32'h0);
    tick();
    check_eq("ar_regrant", 32'(d_gnt[0]), 32'b001);
    idle_inputs();
    tick(); tick();

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(399) == 0) rst_n = 1'b0;
      for (int n = 0; n < 3; n++) begin
        if ($urandom_range(7) == 0) cyc[n] = ~cyc[n];
        stb[n] = cyc[n] & ($urandom_range(3) != 0);
        we[n]  = 1'($urandom_range(1));
        sel[4*n +: 4]  = 4'($urandom);
        adr[32*n +: 32] = $urandom;
        dat[32*n +: 32] = $urandom;
      end
      m_ack   = ($urandom_range(3) == 0);
      m_stall = ($urandom_range(7) == 0);
      m_dat   = $urandom;
    end
    idle_inputs();
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
